excess3_to_bcd_serial: RTL

- Decodes a packed multi-digit Excess-3 word back to packed BCD. This is the return path for the BCD-to-Excess-3 converter.
- Processes one digit per clock and flags each invalid Excess-3 code.
- Valid/ready handshake on both sides, so it sits between a stream of Excess-3 data and downstream BCD display or arithmetic logic.

---
 rtl/excess3_to_bcd_serial.sv | 111 +++++++++++
 1 files changed

// File: rtl/excess3_to_bcd_serial.sv
// Serial Excess-3 to packed BCD decoder with valid/ready handshakes on both sides.
// Converts one digit per clock, LSB digit first, and flags each illegal Excess-3 code.
module excess3_to_bcd_serial #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   x3_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  err
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [W-1:0]      shreg, shreg_next;
    logic [W-1:0]      bcd_next;
    logic [DIGITS-1:0] mask_next;
    logic              err_next;
    logic              out_valid_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [3:0]        code;
    logic [3:0]        digit;
    logic              bad;

    assign in_ready = (state == IDLE);

    // Decode of the digit currently at the bottom of the shift register
    always_comb begin
        code  = shreg[3:0];
        bad   = (code < 4'd3) || (code > 4'd12);
        digit = bad ? 4'd0 : (code - 4'd3);
    end

    // Results enter from the top so digit 0 lands at the bottom after DIGITS shifts
    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        bcd_next       = bcd_out;
        mask_next      = err_mask;
        err_next       = err;
        cnt_next       = cnt;
        out_valid_next = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_next = x3_in;
                    bcd_next   = '0;
                    mask_next  = '0;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                shreg_next = shreg >> 4;
                bcd_next   = (bcd_out >> 4) | (W'(digit) << (W - 4));
                mask_next  = (err_mask >> 1) | (DIGITS'(bad) << (DIGITS - 1));
                cnt_next   = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    err_next       = |mask_next;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bcd_out   <= '0;
            err_mask  <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bcd_out   <= bcd_next;
            err_mask  <= mask_next;
            err       <= err_next;
            cnt       <= cnt_next;
            out_valid <= out_valid_next;
        end
    end

endmodule
